riscv_muldiv_unit: RTL
======================

Name: riscv_muldiv_unit

Overview:
Iterative RV32M/RV64M multiply-divide unit for the pipelined RISC-V core. It sits beside the EX-stage ALU. The pipeline issues M-extension ops over a start/ready handshake and holds EX while busy is high. Width is parametrised by XLEN, so one block covers RV32 and RV64. Illegal-division corner cases are resolved per the ISA, never trapped.

Parameters:
XLEN, 32, operand/result width; even, >= 8.
CNT_W, $clog2(XLEN+1), iteration counter width; derived, not overridden.

Ports:
clk     input   1      rising-edge clock
reset   input   1      asynchronous, active-high reset
start   input   1      request valid; accepted when start && ready && !flush
op      input   3      funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1     input   XLEN   operand A / dividend
rs2     input   XLEN   operand B / divisor
flush   input   1      abort in-flight op (branch mispredict / pipeline flush)
ready   output  1      combinational, = (state == IDLE) || (state == DONE)
busy    output  1      registered, high in CALC and FIX
done    output  1      registered, one-cycle pulse with valid result
result  output  XLEN   registered; holds its last value until the next done

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0. Reset mid-operation discards the op; no done is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- Acceptance at edge N:
  - Operands are latched. Signed ops convert to magnitudes; the sign flags are recorded.
  - counter=0, state goes to CALC, busy goes high.
- CALC:
  - One iteration per edge.
  - MUL*: shift-add on a 2*XLEN accumulator.
  - DIV*/REM*: restoring division, one quotient bit per edge.
  - After XLEN iterations (edges N+1..N+XLEN), state goes to FIX.
- FIX, edge N+XLEN+1:
  - Apply sign correction:
    - product negated if sign flags differ (MULHSU: rs2 is unsigned);
    - quotient negated if dividend and divisor signs differ;
    - remainder takes the dividend sign.
  - Select the result:
    - MUL: low XLEN bits;
    - MULH/MULHSU/MULHU: high XLEN bits;
    - DIV*: quotient;
    - REM*: remainder.
  - Register the selected value into result, drive done=1, busy=0, state goes to DONE.
  - Total latency: done is visible XLEN+1 cycles after the acceptance edge.
- DONE: lasts one cycle, then state goes to IDLE. ready is high in DONE, so back-to-back acceptance is allowed in the done cycle.
- Division special cases (exact ISA results):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - DIV of most-negative by -1 gives most-negative; REM of the same gives 0.
- start while busy: ignored, no state change.
- flush:
  - Any state goes to IDLE at the next edge; done is suppressed; result is unchanged.
  - If start and flush are both high, flush wins and the request is not accepted.
- op and operands are sampled only at acceptance; changes afterwards have no effect.

Optional Feature:
RISCV_MULDIV_EARLY_OUT_EN
- Defined: divisor==0, signed overflow, or a multiply with either operand zero bypasses CALC. Acceptance goes straight to FIX-equivalent logic, and done is high 1 cycle after the acceptance edge.
- Undefined: every op takes the full XLEN+1 latency. Results are identical either way.

Decomposition:
- Package riscv_muldiv_pkg holds:
  - op encodings MD_MUL..MD_REMU (3-bit localparams);
  - the state encoding IDLE/CALC/FIX/DONE;
  - the helper constant for most-negative XLEN.
- One natural sub-module, riscv_div_step: a combinational single restoring-division step. Inputs are partial remainder, divisor, and dividend bit; outputs are next remainder and quotient bit. It is instantiated once inside the iterative loop.
- The multiply step stays inline.

Test Plan:
1. XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB. done exactly 33 cycles after acceptance, single-cycle pulse; busy high in the intervening cycles.
2. High-half multiplies -> required results:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000;
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed and unsigned division, each issued back-to-back in the done cycle -> no lost request:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF;
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Division corner cases -> required results:
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5;
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
   - Latency is 1 cycle with RISCV_MULDIV_EARLY_OUT_EN, 33 without.
5. Flush and ignored start:
   - flush 10 cycles into a DIVU -> no done, busy low next cycle, result unchanged.
   - A new start is accepted the cycle after; a start pulsed while busy is ignored.
   - start+flush in the same cycle -> not accepted.
6. reset asserted asynchronously mid-MUL (between clock edges) -> busy, done, result go to 0 immediately. After release, the unit accepts a fresh MULHU and completes normally.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg
// Shared definitions for the iterative RV32M/RV64M multiply-divide unit:
// funct3 op encodings, FSM state encoding, and a most-negative-value helper.
// No ports (package).

package riscv_muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    localparam int MD_MAX_XLEN = 128;

    // Most-negative two's-complement value for an xlen-bit word, returned
    // zero-extended to MD_MAX_XLEN; callers truncate to their own width.
    function automatic logic [MD_MAX_XLEN-1:0] md_most_neg(input int xlen);
        logic [MD_MAX_XLEN-1:0] v;
        v           = '0;
        v[xlen-1]   = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// riscv_div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference if it
// did not borrow.
// Ports:
//   rem_in   [XLEN-1:0]  partial remainder (always < divisor)
//   divisor  [XLEN-1:0]  divisor magnitude
//   bit_in               next dividend bit, MSB first
//   rem_out  [XLEN-1:0]  next partial remainder
//   q_bit                quotient bit produced by this step

module riscv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            bit_in,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    // On a failed trial the shifted value is below the divisor, so it fits.
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
// Iterative M-extension multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, followed by a sign-fix cycle. Division corner cases give ISA results.
// Optional build macro: RISCV_MULDIV_EARLY_OUT_EN -- divide-by-zero, signed
// overflow and multiply-by-zero skip CALC (done 1 cycle after acceptance).
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start, op         request valid and funct3 opcode
//   rs1, rs2          operands (dividend / divisor)
//   flush             abort any in-flight op
//   ready             combinational: idle or done, may accept
//   busy, done        registered status; done is a one-cycle result pulse
//   result            registered result, held until the next done
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | XLEN shift-add / restoring-divide iterations
// FIX   | sign correction and result select
// DONE  | result valid for one cycle, next request may be accepted

module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
`ifdef RISCV_MULDIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(md_most_neg(XLEN));
`endif

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Multiply: {product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              dz_q, dz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              a_signed, b_signed;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_rem;
    logic              div_q;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, sel_result;

    assign ready  = (state_q == IDLE) || (state_q == DONE);
    assign accept = start && ready && !flush;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    assign a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    assign b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    assign sign_a   = a_signed && rs1[XLEN-1];
    assign sign_b   = b_signed && rs2[XLEN-1];
    assign mag_a    = sign_a ? -rs1 : rs1;
    assign mag_b    = sign_b ? -rs2 : rs2;

    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    riscv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc_q[2*XLEN-1:XLEN]),
        .divisor (opb_q),
        .bit_in  (acc_q[XLEN-1]),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );

    // Divide-by-zero naturally leaves |rs1| as remainder, which the remainder
    // sign fix turns back into rs1; only the quotient needs overriding.
    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quot_fix = dz_q ? '1 : ((sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    assign rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        sel_result = rem_fix;
        case (op_q)
            MD_MUL:                       sel_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: sel_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              sel_result = quot_fix;
            MD_REM, MD_REMU:              sel_result = rem_fix;
            default:                      sel_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        result_d = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (accept) begin
                        op_d    = op;
                        sa_d    = sign_a;
                        sb_d    = sign_b;
                        dz_d    = (rs2 == '0);
                        opb_d   = mag_b;
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        cnt_d   = '0;
                        state_d = CALC;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
                        // Preload acc with the final magnitudes and go to FIX.
                        if (op[2] && (rs2 == '0)) begin
                            acc_d   = {mag_a, {XLEN{1'b1}}};
                            state_d = FIX;
                        end else if (((op == MD_DIV) || (op == MD_REM)) &&
                                     (rs1 == MOST_NEG) && (rs2 == '1)) begin
                            acc_d   = {{XLEN{1'b0}}, MOST_NEG};
                            state_d = FIX;
                        end else if (!op[2] && ((rs1 == '0) || (rs2 == '0))) begin
                            acc_d   = '0;
                            state_d = FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        acc_d = {div_rem, acc_q[XLEN-2:0], div_q};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = sel_result;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule
